// File: rtl/setting_reg.sv
// Settings-bus register. It loads set_data when the strobe addresses ADDR,
// and returns to AT_RESET on a synchronous reset.
module setting_reg #(
  parameter logic [7:0]       ADDR     = 8'd0,
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] AT_RESET = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  output logic [WIDTH-1:0] value
);

  // Narrow instances ignore the upper data bits.
  logic unused_data;
  assign unused_data = ^set_data;

  always_ff @(posedge clock) begin
    if (reset)
      value <= AT_RESET;
    else if (set_stb && (set_addr == ADDR))
      value <= set_data[WIDTH-1:0];
  end

endmodule

// File: rtl/tx_power_gate.sv
// TX power gate. Samples pass to the DUC only around bursts whose power
// reaches the threshold, with a pre-roll delay line and a holdoff tail.
module tx_power_gate #(
  parameter logic [7:0] BASE    = 8'd0,
  parameter int         PREROLL = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  output logic [31:0] duc_in_sample,
  input  logic        duc_in_strobe,
  input  logic [31:0] bb_sample,
  output logic        bb_strobe,
  output logic        gate_open,
  output logic [15:0] burst_count
);

  localparam logic [7:0] REG_THRESHOLD = BASE;
  localparam logic [7:0] REG_HOLD      = BASE + 8'd1;

  logic [31:0] threshold;
  logic [16:0] hold_reg;
  logic [15:0] holdoff;
  logic        bypass;

  setting_reg #(.ADDR(REG_THRESHOLD), .WIDTH(32), .AT_RESET(32'hFFFF_FFFF)) u_threshold (
    .clock    (clock),
    .reset    (reset),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data),
    .value    (threshold)
  );

  setting_reg #(.ADDR(REG_HOLD), .WIDTH(17), .AT_RESET(17'd0)) u_hold (
    .clock    (clock),
    .reset    (reset),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data),
    .value    (hold_reg)
  );

  assign holdoff = hold_reg[15:0];
  assign bypass  = hold_reg[16];

  logic               strobe;
  logic signed [15:0] i_s;
  logic signed [15:0] q_s;
  logic signed [31:0] i_sq;
  logic signed [31:0] q_sq;
  logic [31:0]        power;
  logic               above;
  logic               gate;
  logic [21:0]        cnt;
  logic [21:0]        cnt_load;
  logic [31:0]        d [PREROLL];

  assign strobe    = duc_in_strobe & enable;
  assign bb_strobe = strobe;

  // Each square is at most 2^30, so the sum fits unsigned in 32 bits.
  assign i_s   = bb_sample[31:16];
  assign q_s   = bb_sample[15:0];
  assign i_sq  = i_s * i_s;
  assign q_sq  = q_s * q_s;
  assign power = $unsigned(i_sq) + $unsigned(q_sq);

  assign above    = bypass | (power >= threshold);
  assign gate     = above | (cnt != 22'd0);
  assign cnt_load = 22'(PREROLL) + {6'd0, holdoff};

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < PREROLL; i++) d[i] <= '0;
      cnt           <= '0;
      duc_in_sample <= '0;
      gate_open     <= 1'b0;
      burst_count   <= '0;
    end else if (!enable) begin
      for (int i = 0; i < PREROLL; i++) d[i] <= '0;
      cnt           <= '0;
      duc_in_sample <= '0;
      gate_open     <= 1'b0;
    end else if (strobe) begin
      d[0] <= bb_sample;
      for (int i = 1; i < PREROLL; i++) d[i] <= d[i-1];
      duc_in_sample <= gate ? d[PREROLL-1] : 32'd0;
      if (above)
        cnt <= cnt_load;
      else if (cnt != 22'd0)
        cnt <= cnt - 22'd1;
      gate_open <= gate;
      // A retrigger inside an open window keeps gate high, so it never counts.
      if (gate && !gate_open)
        burst_count <= burst_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_tx_power_gate.sv
// Self-checking bench for tx_power_gate: directed burst scenarios plus a
// randomized phase, all checked against a trigger-window reference model.
module tb_tx_power_gate;

  localparam int P = 8;

  logic        clock = 1'b0;
  logic        reset, enable, set_stb, duc_in_strobe;
  logic [7:0]  set_addr;
  logic [31:0] set_data, bb_sample, duc_in_sample;
  logic        bb_strobe, gate_open;
  logic [15:0] burst_count;

  always #5 clock = ~clock;

  tx_power_gate #(.BASE(8'd0), .PREROLL(P)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .set_stb       (set_stb),
    .set_addr      (set_addr),
    .set_data      (set_data),
    .duc_in_sample (duc_in_sample),
    .duc_in_strobe (duc_in_strobe),
    .bb_sample     (bb_sample),
    .bb_strobe     (bb_strobe),
    .gate_open     (gate_open),
    .burst_count   (burst_count)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int nz;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: every strobe since the last flush has an index; a trigger at
  // index t keeps the gate open through index t+P+holdoff, and an open gate
  // at index s emits the sample that entered at index s-P.
  logic [31:0] m_hist [64];
  int          m_idx;
  longint      m_end;
  bit          m_gate_prev;
  logic [31:0] m_out;
  logic [15:0] m_bursts;
  logic [31:0] m_thr;
  logic [15:0] m_hold;
  bit          m_byp;

  task automatic model_edge(input logic rst, en, ds, stb, input logic [7:0] a,
                            input logic [31:0] dat, smp);
    longint ii, qq, pw;
    bit     above, g;
    if (rst) begin
      m_idx = 0; m_end = -1; m_gate_prev = 0; m_out = 0; m_bursts = 0;
      m_thr = 32'hFFFF_FFFF; m_hold = 0; m_byp = 0;
      return;
    end
    if (!en) begin
      m_idx = 0; m_end = -1; m_gate_prev = 0; m_out = 0;
    end else if (ds) begin
      ii = $signed(smp[31:16]);
      qq = $signed(smp[15:0]);
      pw = ii * ii + qq * qq;
      above = m_byp || (pw >= longint'(m_thr));
      g = above || (longint'(m_idx) <= m_end);
      m_out = (g && m_idx >= P) ? m_hist[(m_idx - P) % 64] : 32'd0;
      m_hist[m_idx % 64] = smp;
      if (above) m_end = longint'(m_idx) + P + m_hold;
      if (g && !m_gate_prev) m_bursts++;
      m_gate_prev = g;
      m_idx++;
    end
    if (stb && a == 8'd0) m_thr = dat;
    if (stb && a == 8'd1) begin
      m_hold = dat[15:0];
      m_byp  = dat[16];
    end
  endtask

  task automatic cyc(input logic rst, en, ds, stb, input logic [7:0] a,
                     input logic [31:0] dat, smp);
    reset = rst; enable = en; duc_in_strobe = ds; set_stb = stb;
    set_addr = a; set_data = dat; bb_sample = smp;
    #1;
    check_eq("bb_strobe", {31'd0, bb_strobe}, {31'd0, ds & en});
    model_edge(rst, en, ds, stb, a, dat, smp);
    @(posedge clock);
    #1;
    check_eq("duc_in_sample", duc_in_sample, m_out);
    check_eq("gate_open", {31'd0, gate_open}, {31'd0, m_gate_prev});
    check_eq("burst_count", {16'd0, burst_count}, {16'd0, m_bursts});
    if (!rst && en && ds && duc_in_sample != 32'd0) nz++;
  endtask

  task automatic setup(input logic [31:0] thr, input logic [31:0] hold);
    cyc(1, 0, 0, 0, 8'd0, 0, 0);
    cyc(0, 1, 0, 1, 8'd0, thr, 0);
    cyc(0, 1, 0, 1, 8'd1, hold, 0);
    nz = 0;
  endtask

  // Continuous (or every-other-cycle) strobes; samples t1/t2 carry 'big',
  // enable drops for one cycle at strobe index 'dis'.
  task automatic burst_run(input int n, t1, t2, dis, input logic [31:0] big, input bit toggle);
    int i = 0;
    int c = 0;
    while (i < n) begin
      if (toggle && (c % 2 == 1))
        cyc(0, 1, 0, 0, 8'd2, 0, $urandom);
      else if (i == dis) begin
        cyc(0, 0, 1, 0, 8'd2, 0, 32'h0001_0001);
        check_eq("flush_out", duc_in_sample, 32'd0);
        check_eq("flush_gate", {31'd0, gate_open}, 32'd0);
        i++;
      end else begin
        cyc(0, 1, 1, 0, 8'd2, 0, (i == t1 || i == t2) ? big : 32'h0001_0001);
        i++;
      end
      c++;
    end
  endtask

  initial begin
    reset = 1; enable = 0; set_stb = 0; duc_in_strobe = 0;
    set_addr = 0; set_data = 0; bb_sample = 0;
    @(posedge clock);
    #1;
    cyc(1, 1, 1, 1, 8'd0, 32'h1, 32'h7FFF_7FFF);
    check_eq("rst_out", duc_in_sample, 32'd0);
    check_eq("rst_gate", {31'd0, gate_open}, 32'd0);
    check_eq("rst_bursts", {16'd0, burst_count}, 32'd0);
    // Reset must have blocked the write: default threshold is never reached.
    cyc(0, 1, 1, 0, 8'd2, 0, 32'h8000_8000);
    check_eq("rst_thr_gate", {31'd0, gate_open}, 32'd0);

    setup(32'h0010_0000, 32'd4);
    burst_run(40, 20, -1, -1, 32'h0800_0000, 0);
    check_eq("single_nz", nz, 13);
    check_eq("single_bursts", {16'd0, burst_count}, 32'd1);

    setup(32'h0010_0000, 32'd4);
    burst_run(40, 20, 23, -1, 32'h0800_0000, 0);
    check_eq("retrig_nz", nz, 16);
    check_eq("retrig_bursts", {16'd0, burst_count}, 32'd1);

    setup(32'h0010_0000, 32'h0001_0000);
    for (int i = 0; i < 40; i++) cyc(0, 1, 1, 0, 8'd2, 0, $urandom | 32'h1);
    check_eq("bypass_nz", nz, 32);
    check_eq("bypass_gate", {31'd0, gate_open}, 32'd1);

    setup(32'h0010_0000, 32'd4);
    burst_run(40, 20, -1, -1, 32'h0800_0000, 1);
    check_eq("toggle_nz", nz, 13);
    check_eq("toggle_bursts", {16'd0, burst_count}, 32'd1);

    setup(32'h0010_0000, 32'd4);
    burst_run(40, 20, -1, 22, 32'h0800_0000, 0);
    check_eq("flush_nz", nz, 2);
    check_eq("flush_bursts", {16'd0, burst_count}, 32'd1);

    setup(32'h0010_0000, 32'd4);
    burst_run(40, 20, -1, -1, 32'h0400_0000, 0);
    check_eq("equal_nz", nz, 13);
    check_eq("equal_bursts", {16'd0, burst_count}, 32'd1);

    setup(32'h0010_0001, 32'd4);
    burst_run(40, 20, -1, -1, 32'h0400_0000, 0);
    check_eq("below_nz", nz, 0);
    check_eq("below_bursts", {16'd0, burst_count}, 32'd0);

    // Random traffic, including writes coinciding with strobes.
    setup(32'h0100_0000, 32'd3);
    for (int k = 0; k < 1500; k++) begin
      logic        r_rst, r_en, r_ds, r_stb;
      logic [7:0]  r_a;
      logic [31:0] r_d, r_s;
      r_rst = ($urandom_range(0, 199) == 0);
      r_en  = ($urandom_range(0, 29) != 0);
      r_ds  = ($urandom_range(0, 9) < 7);
      r_stb = ($urandom_range(0, 9) == 0);
      r_a   = 8'($urandom_range(0, 3));
      if (r_a == 8'd0)
        r_d = $urandom >> $urandom_range(1, 12);
      else if (r_a == 8'd1)
        r_d = {15'd0, ($urandom_range(0, 7) == 0), 16'($urandom_range(0, 20))};
      else
        r_d = $urandom;
      case ($urandom_range(0, 2))
        0:       r_s = $urandom;
        1:       r_s = $urandom & 32'h03FF_03FF;
        default: r_s = $urandom & 32'h003F_003F;
      endcase
      cyc(r_rst, r_en, r_ds, r_stb, r_a, r_d, r_s);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
